// File: rtl/data_memory_pkg.sv
// Shared definitions for the sized data memory: funct3 size codes, FSM state type, data width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package data_memory_pkg;

   localparam int DATA_WIDTH = 32;

   // RISC-V funct3 encodings for load/store size
   localparam logic [2:0] SIZE_B  = 3'b000;
   localparam logic [2:0] SIZE_H  = 3'b001;
   localparam logic [2:0] SIZE_W  = 3'b010;
   localparam logic [2:0] SIZE_BU = 3'b100;
   localparam logic [2:0] SIZE_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/data_memory_align.sv
// Byte-lane steering for sized accesses: store byte enables/data placement, size legality, load extract/extend.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
//
// Ports:
//   size     funct3 access size
//   lane     byte address bits [1:0]
//   is_store 1 = store (unsigned sizes are illegal for stores)
//   wr_data  right-aligned store data
//   rd_word  full memory word for load extraction
//   byte_en  per-lane write enables
//   wr_word  store data replicated so each enabled lane carries the right bytes
//   bad      misaligned access or illegal size
//   ld_data  selected byte/half/word shifted to bit 0 and sign/zero extended
module data_memory_align
   import data_memory_pkg::*;
(
   input  logic [2:0]            size,
   input  logic [1:0]            lane,
   input  logic                  is_store,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [DATA_WIDTH-1:0] rd_word,
   output logic [3:0]            byte_en,
   output logic [DATA_WIDTH-1:0] wr_word,
   output logic                  bad,
   output logic [DATA_WIDTH-1:0] ld_data
);

   logic [DATA_WIDTH-1:0] shifted;

   always_comb begin
      shifted = rd_word >> {lane, 3'b000};
      byte_en = 4'b0000;
      wr_word = wr_data;
      bad     = 1'b0;
      ld_data = '0;

      case (size)
         SIZE_B, SIZE_BU: begin
            byte_en = 4'b0001 << lane;
            // Replicating the byte puts it in whichever lane is enabled
            wr_word = {4{wr_data[7:0]}};
            bad     = is_store && (size == SIZE_BU);
            ld_data = (size == SIZE_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                       : {24'b0, shifted[7:0]};
         end
         SIZE_H, SIZE_HU: begin
            byte_en = lane[1] ? 4'b1100 : 4'b0011;
            wr_word = {2{wr_data[15:0]}};
            bad     = lane[0] || (is_store && (size == SIZE_HU));
            ld_data = (size == SIZE_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                       : {16'b0, shifted[15:0]};
         end
         SIZE_W: begin
            byte_en = 4'b1111;
            bad     = (lane != 2'b00);
            ld_data = rd_word;
         end
         default: begin
            bad = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressed data memory with RISC-V sized loads/stores, byte-lane writes and error flagging.
// Latency: load response in the cycle after edge N+READ_LATENCY; store/error after edge N+1 (N = accept edge).
// Backpressure: req_ready_o low while a request is outstanding; one request in flight at a time.
//
// Ports:
//   clock_i, reset_ni  clock and asynchronous active-low reset
//   req_valid_i/req_ready_o  request handshake
//   addr_i, wr_enable_i, size_i, wr_data_i  request fields
//   rsp_valid_o  one-cycle response pulse; rd_data_o/error_o meaningful only then, 0 otherwise
module data_memory_sized
   import data_memory_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DEPTH_WORDS  = 1024,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clock_i,
   input  logic                  reset_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic                  wr_enable_i,
   input  logic [2:0]            size_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   output logic                  rsp_valid_o,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  error_o
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [1:0] CNT_INIT = 2'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

   state_t                state_q, state_d;
   logic [1:0]            cnt_q, cnt_d;
   logic                  ready_q, ready_d;
   logic                  rsp_q, rsp_d;
   logic                  err_out_q, err_out_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

   // Captured at acceptance and held until the response
   logic                  err_q;
   logic                  store_q;
   logic [2:0]            size_q;
   logic [1:0]            lane_q;
   logic [DATA_WIDTH-1:0] word_q;

   logic [IDX_W-1:0]      idx;
   logic                  range_err;
   logic                  req_err;
   logic                  accept;

   logic [2:0]            aln_size;
   logic [1:0]            aln_lane;
   logic [3:0]            byte_en;
   logic [DATA_WIDTH-1:0] wr_word;
   logic                  aln_bad;
   logic [DATA_WIDTH-1:0] ld_data;

   assign idx = addr_i[2 +: IDX_W];

   // Any set address bit above the word index means the word is past the array
   generate
      if (ADDR_WIDTH > IDX_W + 2) begin : g_hi_bits
         assign range_err = |addr_i[ADDR_WIDTH-1:IDX_W+2];
      end else begin : g_no_hi_bits
         assign range_err = 1'b0;
      end
   endgenerate

   // One aligner serves both directions: in IDLE it checks and steers the live
   // request; afterwards it extracts from the held word using the held size/lane.
   assign aln_size = (state_q == IDLE) ? size_i        : size_q;
   assign aln_lane = (state_q == IDLE) ? addr_i[1:0]   : lane_q;

   data_memory_align u_align (
      .size     (aln_size),
      .lane     (aln_lane),
      .is_store (wr_enable_i),
      .wr_data  (wr_data_i),
      .rd_word  (word_q),
      .byte_en  (byte_en),
      .wr_word  (wr_word),
      .bad      (aln_bad),
      .ld_data  (ld_data)
   );

   assign req_err = aln_bad || range_err;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      accept     = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid_i && ready_q) begin
               accept = 1'b1;
               if (!wr_enable_i && !req_err && (READ_LATENCY > 1)) begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end else begin
                  state_d = RESP;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 2'd0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered, so the pulse lands one edge after RESP is entered
      ready_d    = (state_d == IDLE);
      rsp_d      = (state_q == RESP);
      err_out_d  = rsp_d && err_q;
      data_out_d = (rsp_d && !err_q && !store_q) ? ld_data : '0;
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= IDLE;
         cnt_q      <= 2'd0;
         ready_q    <= 1'b0;
         rsp_q      <= 1'b0;
         err_out_q  <= 1'b0;
         data_out_q <= '0;
         err_q      <= 1'b0;
         store_q    <= 1'b0;
         size_q     <= SIZE_W;
         lane_q     <= 2'b00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ready_q    <= ready_d;
         rsp_q      <= rsp_d;
         err_out_q  <= err_out_d;
         data_out_q <= data_out_d;
         if (accept) begin
            err_q   <= req_err;
            store_q <= wr_enable_i;
            size_q  <= size_i;
            lane_q  <= addr_i[1:0];
         end
      end
   end

   // Array and read word are not reset; a completed store survives reset
   always_ff @(posedge clock_i) begin
      if (accept && wr_enable_i && !req_err) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
               mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
         end
      end
      if (accept) begin
         word_q <= mem[idx];
      end
   end

   assign req_ready_o = ready_q;
   assign rsp_valid_o = rsp_q;
   assign error_o     = err_out_q;
   assign rd_data_o   = data_out_q;

endmodule

// File: tb/tb_data_memory_sized.sv
module tb_data_memory_sized;

   localparam int AW    = 32;
   localparam int DEPTH = 16;
   localparam int RL    = 3;

   logic          clock_i = 1'b0;
   logic          reset_ni = 1'b0;
   logic          req_valid_i = 1'b0;
   logic          req_ready_o;
   logic [AW-1:0] addr_i = '0;
   logic          wr_enable_i = 1'b0;
   logic [2:0]    size_i = 3'b010;
   logic [31:0]   wr_data_i = '0;
   logic          rsp_valid_o;
   logic [31:0]   rd_data_o;
   logic          error_o;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int rsp_count = 0;

   typedef struct {
      logic        err;
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   data_memory_sized #(
      .ADDR_WIDTH   (AW),
      .DEPTH_WORDS  (DEPTH),
      .READ_LATENCY (RL)
   ) dut (
      .clock_i     (clock_i),
      .reset_ni    (reset_ni),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .addr_i      (addr_i),
      .wr_enable_i (wr_enable_i),
      .size_i      (size_i),
      .wr_data_i   (wr_data_i),
      .rsp_valid_o (rsp_valid_o),
      .rd_data_o   (rd_data_o),
      .error_o     (error_o)
   );

   always #5 clock_i = ~clock_i;

   always @(posedge clock_i) cyc <= cyc + 1;

   // Scoreboard: every response is matched against the oldest expectation,
   // including the cycle it should arrive in; idle cycles must read as zero.
   always @(negedge clock_i) begin
      if (reset_ni) begin
         checks++;
         if (rsp_valid_o) begin
            rsp_count++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_rsp cyc=%0d err=%0b data=%h, no response was due", cyc, error_o, rd_data_o);
            end else begin
               mon_e = exp_q.pop_front();
               if (error_o !== mon_e.err || rd_data_o !== mon_e.data || cyc !== mon_e.due) begin
                  failures++;
                  $display("FAIL rsp got err=%0b data=%h cyc=%0d, expected err=%0b data=%h cyc=%0d",
                           error_o, rd_data_o, cyc, mon_e.err, mon_e.data, mon_e.due);
               end
            end
         end else if (error_o !== 1'b0 || rd_data_o !== 32'h0) begin
            failures++;
            $display("FAIL idle_outputs cyc=%0d err=%0b data=%h, expected 0/0", cyc, error_o, rd_data_o);
         end
      end
   end

   task automatic send(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input logic exp_err, input logic [31:0] exp_d);
      exp_t e;
      bit   ok;
      @(negedge clock_i);
      req_valid_i = 1'b1;
      wr_enable_i = wr;
      size_i      = sz;
      addr_i      = a;
      wr_data_i   = d;
      ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (req_ready_o === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clock_i);
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout addr=%h ready=%b, expected ready=1 within 40 cycles", a, req_ready_o);
         req_valid_i = 1'b0;
         return;
      end
      e.err  = exp_err;
      e.data = exp_d;
      e.due  = cyc + 1 + ((wr || exp_err) ? 1 : RL);
      exp_q.push_back(e);
      @(posedge clock_i);
      #1 req_valid_i = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int n = 0; n < 40 && exp_q.size() != 0; n++) @(negedge clock_i);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_drain pending=%0d, expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      reset_ni = 1'b0;
      repeat (2) @(negedge clock_i);
      checks++;
      if (req_ready_o !== 1'b0 || rsp_valid_o !== 1'b0 || error_o !== 1'b0 || rd_data_o !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs ready=%b rsp=%b err=%b data=%h, expected all 0",
                  req_ready_o, rsp_valid_o, error_o, rd_data_o);
      end
      reset_ni = 1'b1;
      #1;
      checks++;
      if (req_ready_o !== 1'b0) begin
         failures++;
         $display("FAIL ready_before_edge ready=%b, expected 0", req_ready_o);
      end
      @(posedge clock_i);
      #1;
      checks++;
      if (req_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL ready_after_release ready=%b, expected 1", req_ready_o);
      end
   endtask

   task automatic test_word();
      send(1'b1, 3'b010, 32'h0, 32'h5555_5555, 1'b0, 32'h0);
      send(1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 32'h5555_5555);
      drain("word");
   endtask

   task automatic test_sized_loads();
      send(1'b1, 3'b010, 32'h4, 32'hAAAA_8081, 1'b0, 32'h0);
      send(1'b0, 3'b000, 32'h4, 32'h0, 1'b0, 32'hFFFF_FF81);
      send(1'b0, 3'b100, 32'h4, 32'h0, 1'b0, 32'h0000_0081);
      send(1'b0, 3'b001, 32'h6, 32'h0, 1'b0, 32'hFFFF_AAAA);
      send(1'b0, 3'b101, 32'h6, 32'h0, 1'b0, 32'h0000_AAAA);
      send(1'b0, 3'b000, 32'h5, 32'h0, 1'b0, 32'hFFFF_FF80);
      send(1'b0, 3'b001, 32'h4, 32'h0, 1'b0, 32'hFFFF_8081);
      drain("sized_loads");
   endtask

   task automatic test_sized_stores();
      send(1'b1, 3'b010, 32'h8, 32'h0, 1'b0, 32'h0);
      send(1'b1, 3'b000, 32'h9, 32'hFFFF_FF7F, 1'b0, 32'h0);
      send(1'b1, 3'b001, 32'hA, 32'hFFFF_1234, 1'b0, 32'h0);
      send(1'b0, 3'b010, 32'h8, 32'h0, 1'b0, 32'h1234_7F00);
      send(1'b0, 3'b100, 32'hB, 32'h0, 1'b0, 32'h0000_0012);
      send(1'b0, 3'b101, 32'h8, 32'h0, 1'b0, 32'h0000_7F00);
      drain("sized_stores");
   endtask

   task automatic test_errors();
      send(1'b0, 3'b010, 32'h2, 32'h0, 1'b1, 32'h0);
      send(1'b0, 3'b001, 32'h1, 32'h0, 1'b1, 32'h0);
      send(1'b1, 3'b001, 32'h3, 32'h0000_FFFF, 1'b1, 32'h0);
      send(1'b0, 3'b011, 32'h0, 32'h0, 1'b1, 32'h0);
      send(1'b1, 3'b100, 32'h0, 32'hDEAD_BEEF, 1'b1, 32'h0);
      send(1'b1, 3'b110, 32'h0, 32'hDEAD_BEEF, 1'b1, 32'h0);
      send(1'b0, 3'b010, DEPTH * 4, 32'h0, 1'b1, 32'h0);
      send(1'b1, 3'b010, DEPTH * 4, 32'h0000_0001, 1'b1, 32'h0);
      // Nothing above may have reached the array
      send(1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 32'h5555_5555);
      drain("errors");
   endtask

   task automatic test_back_to_back();
      logic [31:0] addrs [4];
      logic [31:0] datas [4];
      int          base;
      bit          ok;
      exp_t        e;
      addrs[0] = 32'h4; datas[0] = 32'hAAAA_8081;
      addrs[1] = 32'h0; datas[1] = 32'h5555_5555;
      addrs[2] = 32'h8; datas[2] = 32'h1234_7F00;
      addrs[3] = 32'h4; datas[3] = 32'hAAAA_8081;
      base = rsp_count;
      @(negedge clock_i);
      req_valid_i = 1'b1;
      wr_enable_i = 1'b0;
      size_i      = 3'b010;
      for (int k = 0; k < 4; k++) begin
         addr_i = addrs[k];
         ok = 1'b0;
         for (int n = 0; n < 40; n++) begin
            if (req_ready_o === 1'b1) begin
               ok = 1'b1;
               break;
            end
            @(negedge clock_i);
         end
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL b2b_accept k=%0d ready=%b, expected 1", k, req_ready_o);
            break;
         end
         e.err  = 1'b0;
         e.data = datas[k];
         e.due  = cyc + 1 + RL;
         exp_q.push_back(e);
         @(posedge clock_i);
         for (int j = 0; j < RL; j++) begin
            @(negedge clock_i);
            checks++;
            if (req_ready_o !== 1'b0) begin
               failures++;
               $display("FAIL b2b_busy k=%0d j=%0d ready=%b, expected 0", k, j, req_ready_o);
            end
         end
         @(negedge clock_i);
         checks++;
         if (req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready_return k=%0d ready=%b, expected 1", k, req_ready_o);
         end
      end
      req_valid_i = 1'b0;
      drain("b2b");
      checks++;
      if (rsp_count - base !== 4) begin
         failures++;
         $display("FAIL b2b_pulse_count got=%0d, expected 4", rsp_count - base);
      end
   endtask

   task automatic test_reset_mid_wait();
      int base;
      send(1'b1, 3'b010, 32'h10, 32'hCAFE_F00D, 1'b0, 32'h0);
      drain("pre_reset");
      send(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hCAFE_F00D);
      // Load now sits in WAIT; its response must never appear
      reset_ni = 1'b0;
      exp_q.delete();
      base = rsp_count;
      #1;
      checks++;
      if (req_ready_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset ready=%b rsp=%b, expected 0/0", req_ready_o, rsp_valid_o);
      end
      repeat (2) @(negedge clock_i);
      reset_ni = 1'b1;
      #1;
      checks++;
      if (req_ready_o !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_release ready=%b, expected 0", req_ready_o);
      end
      @(posedge clock_i);
      #1;
      checks++;
      if (req_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL mid_reset_ready ready=%b, expected 1", req_ready_o);
      end
      repeat (6) @(negedge clock_i);
      checks++;
      if (rsp_count !== base) begin
         failures++;
         $display("FAIL dropped_rsp pulses=%0d, expected 0", rsp_count - base);
      end
      send(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hCAFE_F00D);
      drain("post_reset");
   endtask

   initial begin
      test_reset();
      test_word();
      test_sized_loads();
      test_sized_stores();
      test_errors();
      test_back_to_back();
      test_reset_mid_wait();
      repeat (3) @(negedge clock_i);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/data_memory_sized.md
Name: data_memory_sized

Overview:
Parametrised successor to the word-only data memory, serving the core's load/store unit. Supports RISC-V sized accesses (byte, half, word, signed and unsigned loads) with byte-lane writes. Uses a valid/ready request and a one-cycle response pulse, with configurable read latency. Flags misaligned, out-of-range and illegal-size requests instead of silently corrupting memory.

Parameters:
ADDR_WIDTH, 32, byte-address width of addr_i
DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 4
READ_LATENCY, 1, cycles from load acceptance to data; legal range 1..4

Ports:
clock_i  in  1  rising-edge clock
reset_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  request present
req_ready_o  out  1  block can accept a request this cycle
addr_i  in  ADDR_WIDTH  byte address
wr_enable_i  in  1  1 = store, 0 = load
size_i  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
wr_data_i  in  32  store data, right-aligned
rsp_valid_o  out  1  one-cycle response pulse
rd_data_o  out  32  load result, extended to 32 bits; 0 for stores and errors
error_o  out  1  request rejected; valid only when rsp_valid_o = 1

Behaviour:
- Reset (reset_ni low, asynchronous):
  - FSM goes to IDLE.
  - req_ready_o, rsp_valid_o and error_o are 0; rd_data_o is 0.
  - Memory array contents are not reset.
  - req_ready_o rises on the first clock edge after reset_ni is released.
- Handshake:
  - A request is accepted on an edge where req_valid_i = 1 and req_ready_o = 1.
  - Only one request is outstanding at a time; req_ready_o = 1 only in IDLE.
- FSM states: IDLE, WAIT, RESP.
  - IDLE with an accepted load: go to WAIT when READ_LATENCY > 1, otherwise go to RESP.
  - IDLE with an accepted store or error: go to RESP.
  - WAIT: counter starts at READ_LATENCY-2 and decrements; go to RESP when it reaches 0.
  - RESP: rsp_valid_o = 1 for exactly one cycle, then go to IDLE. req_ready_o returns to 1 in the following cycle.
- Latency, with acceptance at edge N:
  - Load: rsp_valid_o is high in the cycle following edge N+READ_LATENCY.
  - Store or error: rsp_valid_o is high in the cycle following edge N+1.
- Word index is addr_i[2 +: log2(DEPTH_WORDS)]. Lane is addr_i[1:0].
- Store behaviour:
  - The memory is written on the acceptance edge.
  - SB writes wr_data_i[7:0] to the lane selected by addr_i[1:0].
  - SH writes wr_data_i[15:0] to lanes {addr_i[1],0} and {addr_i[1],1}.
  - SW writes all four lanes.
  - Untouched lanes keep their contents.
- Load behaviour:
  - The word is read on the acceptance edge and held through the latency pipeline.
  - The selected byte or half is shifted to bit 0.
  - B and H are sign-extended; BU and HU are zero-extended.
  - A load accepted after a store to the same word returns the updated data.
- Error conditions, checked at acceptance:
  - Half access with addr_i[0] = 1.
  - Word access with addr_i[1:0] != 0.
  - Word index >= DEPTH_WORDS, meaning any nonzero addr_i bits above the index field.
  - size_i in {011, 110, 111}.
  - Store with size_i in {100, 101}.
- Error response: no memory write; error_o = 1 and rd_data_o = 0 during the RESP cycle.
- Reset during WAIT or RESP: the pending response is dropped, no rsp_valid_o pulse occurs, and a store already accepted remains written.
- req_valid_i while req_ready_o = 0 is ignored. The requester must hold it until accepted.
- rd_data_o and error_o return to 0 outside the RESP cycle.

Decomposition:
- Package data_memory_pkg holds:
  - size encoding localparams SIZE_B, SIZE_H, SIZE_W, SIZE_BU, SIZE_HU;
  - state typedef (IDLE, WAIT, RESP);
  - DATA_WIDTH = 32.
- One combinational sub-module, data_memory_align:
  - inputs size, lane and store data; outputs 4-bit byte-enable, lane-shifted write data and misalign/illegal flag;
  - also performs the load extract and sign/zero extension.
- The FSM, latency counter and memory array remain in the top level.

Test Plan:
- Reset, then SW addr 0x0 data 0x55555555, then LW addr 0x0 -> store ack pulse with error_o = 0 and rd_data_o = 0; load returns 0x55555555 READ_LATENCY cycles after acceptance.
- SW addr 0x4 data 0xAAAA8081, then LB 0x4, LBU 0x4, LH 0x6, LHU 0x6 -> 0xFFFFFF81, 0x00000081, 0xFFFFAAAA, 0x0000AAAA.
- SW addr 0x8 data 0, then SB 0x9 data 0x7F and SH 0xA data 0x1234, then LW 0x8 -> 0x12347F00.
- LW 0x2, SH 0x3, size_i 011, SBU-style store size 100, and LW at byte address DEPTH_WORDS*4 -> each returns error_o = 1 with rd_data_o = 0, and memory is unchanged (checked by re-reading).
- READ_LATENCY = 3 with req_valid_i held high for back-to-back loads -> req_ready_o low for 3 cycles after each acceptance; rsp_valid_o pulses exactly once per request.
- Assert reset_ni low while in WAIT after an LW -> no rsp_valid_o pulse; req_ready_o = 0 during reset and 1 one edge after release; a prior store's data is still readable.
